// File: rtl/vscale_htif_pcr_host.sv
// Host-side HTIF PCR access engine: accepts one host CSR command at a time, issues it to the core,
// and returns a completion (response data or timeout abort). Stray responses are drained and counted.
module vscale_htif_pcr_host #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              htif_pcr_req_valid,
    input  logic              htif_pcr_req_ready,
    output logic              htif_pcr_req_rw,
    output logic [ADDR_W-1:0] htif_pcr_req_addr,
    output logic [DATA_W-1:0] htif_pcr_req_data,
    input  logic              htif_pcr_resp_valid,
    output logic              htif_pcr_resp_ready,
    input  logic [DATA_W-1:0] htif_pcr_resp_data,
    output logic              done_valid,
    input  logic              done_ready,
    output logic [DATA_W-1:0] done_data,
    output logic              done_timeout,
    output logic [7:0]        stray_count
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP, DONE} state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [15:0]         timer_q, timer_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                resp_ready_q;
    logic                req_valid_q, req_valid_d;
    logic                req_rw_q, req_rw_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [DATA_W-1:0]   req_data_q, req_data_d;
    logic                done_valid_q, done_valid_d;
    logic [DATA_W-1:0]   done_data_q, done_data_d;
    logic                done_timeout_q, done_timeout_d;
    logic [7:0]          stray_q, stray_d;
    logic                resp_hs;
    logic                expired;

    assign resp_hs = htif_pcr_resp_valid && resp_ready_q;
    assign expired = (timer_q == TIMER_LAST);

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        req_valid_d    = req_valid_q;
        req_rw_d       = req_rw_q;
        req_addr_d     = req_addr_q;
        req_data_d     = req_data_q;
        done_valid_d   = done_valid_q;
        done_data_d    = done_data_q;
        done_timeout_d = done_timeout_q;
        stray_d        = stray_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    req_rw_d    = cmd_rw;
                    req_addr_d  = cmd_addr;
                    req_data_d  = cmd_data;
                    req_valid_d = 1'b1;
                    timer_d     = '0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                timer_d = timer_q + 16'd1;
                if (expired) begin
                    req_valid_d    = 1'b0;
                    done_valid_d   = 1'b1;
                    done_data_d    = '0;
                    done_timeout_d = 1'b1;
                    state_d        = DONE;
                end else if (htif_pcr_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                timer_d = timer_q + 16'd1;
                // A response on the expiry cycle still counts as a real completion.
                if (resp_hs) begin
                    done_valid_d   = 1'b1;
                    done_data_d    = htif_pcr_resp_data;
                    done_timeout_d = 1'b0;
                    state_d        = DONE;
                end else if (expired) begin
                    done_valid_d   = 1'b1;
                    done_data_d    = '0;
                    done_timeout_d = 1'b1;
                    state_d        = DONE;
                end
            end
            DONE: begin
                if (done_ready) begin
                    done_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (resp_hs && (state_q != WAIT_RESP) && (stray_q != 8'hFF)) begin
            stray_d = stray_q + 8'd1;
        end

        // Ready is registered from the next state, so the DONE->IDLE cycle never accepts.
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            cmd_ready_q    <= 1'b0;
            resp_ready_q   <= 1'b0;
            req_valid_q    <= 1'b0;
            req_rw_q       <= 1'b0;
            req_addr_q     <= '0;
            req_data_q     <= '0;
            done_valid_q   <= 1'b0;
            done_data_q    <= '0;
            done_timeout_q <= 1'b0;
            stray_q        <= '0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            cmd_ready_q    <= cmd_ready_d;
            resp_ready_q   <= 1'b1;
            req_valid_q    <= req_valid_d;
            req_rw_q       <= req_rw_d;
            req_addr_q     <= req_addr_d;
            req_data_q     <= req_data_d;
            done_valid_q   <= done_valid_d;
            done_data_q    <= done_data_d;
            done_timeout_q <= done_timeout_d;
            stray_q        <= stray_d;
        end
    end

    assign cmd_ready           = cmd_ready_q;
    assign htif_pcr_req_valid  = req_valid_q;
    assign htif_pcr_req_rw     = req_rw_q;
    assign htif_pcr_req_addr   = req_addr_q;
    assign htif_pcr_req_data   = req_data_q;
    assign htif_pcr_resp_ready = resp_ready_q;
    assign done_valid          = done_valid_q;
    assign done_data           = done_data_q;
    assign done_timeout        = done_timeout_q;
    assign stray_count         = stray_q;

endmodule

// File: tb/tb_vscale_htif_pcr_host.sv
// Bench for vscale_htif_pcr_host with TIMEOUT=16: directed scenarios plus randomized transactions,
// each checked cycle by cycle against a transaction-level timing model.
module tb_vscale_htif_pcr_host;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
    logic [11:0] cmd_addr = '0;
    logic [63:0] cmd_data = '0;
    logic        req_valid, req_ready = 1'b0, req_rw;
    logic [11:0] req_addr;
    logic [63:0] req_data;
    logic        resp_valid = 1'b0, resp_ready;
    logic [63:0] resp_data = '0;
    logic        done_valid, done_ready = 1'b0, done_timeout;
    logic [63:0] done_data;
    logic [7:0]  stray_count;

    int total = 0;
    int passed = 0;
    int exp_stray = 0;

    always #5 clk = ~clk;

    vscale_htif_pcr_host #(.ADDR_W(12), .DATA_W(64), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .htif_pcr_req_valid(req_valid), .htif_pcr_req_ready(req_ready),
        .htif_pcr_req_rw(req_rw), .htif_pcr_req_addr(req_addr), .htif_pcr_req_data(req_data),
        .htif_pcr_resp_valid(resp_valid), .htif_pcr_resp_ready(resp_ready),
        .htif_pcr_resp_data(resp_data),
        .done_valid(done_valid), .done_ready(done_ready),
        .done_data(done_data), .done_timeout(done_timeout),
        .stray_count(stray_count)
    );

    // One transaction. Cycle k is the k-th cycle after the accepting edge; the core raises
    // req_ready in cycle r, answers in cycle r+1+s, and the host waits `hold` cycles on done.
    task automatic run_txn(input string name, input logic rw, input logic [11:0] addr,
                           input logic [63:0] data, input int r, input int s, input int hold,
                           input logic [63:0] rdata);
        int  d, last, rc, waited;
        bit  got;
        logic [63:0] exp_data;
        got      = (r + 1 + s <= TO);
        d        = got ? (r + 1 + s) : TO;
        exp_data = got ? rdata : 64'd0;
        rc       = r + 1 + s;
        last     = (d + 2 + hold > rc + 1) ? d + 2 + hold : rc + 1;

        waited = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (waited >= 50) $display("FAIL %s cmd_ready_wait: got %b want 1", name, cmd_ready);
        else passed++;
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_data = data;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_data = {$urandom, $urandom}; cmd_addr = 12'($urandom);

        for (int k = 1; k <= last; k++) begin
            total++;
            if (req_valid !== (k <= r && k <= TO))
                $display("FAIL %s req_valid c%0d: got %b want %b", name, k, req_valid, (k <= r && k <= TO));
            else passed++;
            if (k <= r && k <= TO) begin
                total++;
                if ({req_rw, req_addr, req_data} !== {rw, addr, data})
                    $display("FAIL %s req_fields c%0d: got %b/%h/%h want %b/%h/%h", name, k,
                             req_rw, req_addr, req_data, rw, addr, data);
                else passed++;
            end
            total++;
            if (done_valid !== (k >= d + 1 && k <= d + 1 + hold))
                $display("FAIL %s done_valid c%0d: got %b want %b", name, k, done_valid,
                         (k >= d + 1 && k <= d + 1 + hold));
            else passed++;
            if (k >= d + 1 && k <= d + 1 + hold) begin
                total++;
                if (done_data !== exp_data || done_timeout !== !got)
                    $display("FAIL %s done_rec c%0d: got %h/%b want %h/%b", name, k,
                             done_data, done_timeout, exp_data, !got);
                else passed++;
            end
            total++;
            if (cmd_ready !== (k >= d + 2 + hold) || resp_ready !== 1'b1)
                $display("FAIL %s readies c%0d: got %b/%b want %b/1", name, k, cmd_ready,
                         resp_ready, (k >= d + 2 + hold));
            else passed++;

            req_ready  = (k == r);
            resp_valid = (k == rc);
            resp_data  = (k == rc) ? rdata : {$urandom, $urandom};
            done_ready = (k == d + 1 + hold);
            if (k == rc && !got && exp_stray < 255) exp_stray++;
            @(negedge clk);
            req_ready = 1'b0; resp_valid = 1'b0; done_ready = 1'b0;
        end
        total++;
        if (stray_count !== 8'(exp_stray))
            $display("FAIL %s stray_count: got %0d want %0d", name, stray_count, exp_stray);
        else passed++;
        $display("txn %s rw=%b addr=%h r=%0d s=%0d hold=%0d -> data=%h timeout=%b",
                 name, rw, addr, r, s, hold, exp_data, !got);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({cmd_ready, req_valid, resp_ready, done_valid, done_timeout} !== 5'b0 ||
            done_data !== 64'd0 || stray_count !== 8'd0 || {req_rw, req_addr, req_data} !== 77'd0)
            $display("FAIL reset_outputs: got %b%b%b%b%b data=%h stray=%0d", cmd_ready, req_valid,
                     resp_ready, done_valid, done_timeout, done_data, stray_count);
        else passed++;
        reset = 1'b1;
        exp_stray = 0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || resp_ready !== 1'b1)
            $display("FAIL reset_release: got cmd_ready=%b resp_ready=%b want 1/1", cmd_ready, resp_ready);
        else passed++;
        $display("txn reset checked");
    endtask

    task automatic test_read();
        run_txn("read", 1'b0, 12'h780, 64'h0, 1, 1, 0, 64'h1234);
    endtask

    task automatic test_write_backpressure();
        run_txn("write_bp", 1'b1, 12'h51E, 64'hDEAD, 6, 2, 0, 64'h0BAD_F00D);
    endtask

    task automatic test_timeout();
        run_txn("timeout", 1'b0, 12'h300, 64'h0, 1, 30, 0, 64'h5555);
        run_txn("timeout_send", 1'b1, 12'h301, 64'h77, TO, 0, 1, 64'h6666);
    endtask

    task automatic test_tie();
        run_txn("tie", 1'b0, 12'h341, 64'h0, 1, TO - 2, 0, 64'hCAFE_BABE);
        run_txn("one_late", 1'b0, 12'h342, 64'h0, 1, TO - 1, 0, 64'hBEEF);
    endtask

    task automatic test_done_hold();
        run_txn("done_hold", 1'b1, 12'h123, 64'hA5A5, 2, 3, 10, 64'h9999_0000_1111);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            run_txn("random", 1'($urandom), 12'($urandom), {$urandom, $urandom},
                    int'($urandom_range(1, 18)), int'($urandom_range(0, 8)),
                    int'($urandom_range(0, 3)), {$urandom, $urandom});
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        for (int w = 0; w < 50 && cmd_ready !== 1'b1; w++) @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 12'h7C0; cmd_data = 64'h42;
        @(negedge clk);
        cmd_valid = 1'b0; req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if ({cmd_ready, req_valid, resp_ready, done_valid} !== 4'b0 || stray_count !== 8'd0 ||
            req_addr !== 12'd0)
            $display("FAIL reset_mid_outputs: got %b%b%b%b stray=%0d addr=%h want 0", cmd_ready,
                     req_valid, resp_ready, done_valid, stray_count, req_addr);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        exp_stray = 0;
        @(negedge clk);
        resp_valid = 1'b1; resp_data = 64'h1111;
        @(negedge clk);
        resp_valid = 1'b0;
        exp_stray = 1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (done_valid !== 1'b0 || cmd_ready !== 1'b1 || stray_count !== 8'(exp_stray))
                $display("FAIL reset_mid_after c%0d: got dv=%b cr=%b stray=%0d want 0/1/%0d", k,
                         done_valid, cmd_ready, stray_count, exp_stray);
            else passed++;
            @(negedge clk);
        end
        $display("txn reset_mid checked");
    endtask

    task automatic test_stray_saturate();
        @(negedge clk);
        resp_valid = 1'b1;
        repeat (300) @(negedge clk);
        resp_valid = 1'b0;
        exp_stray = 255;
        @(negedge clk);
        total++;
        if (stray_count !== 8'd255)
            $display("FAIL stray_saturate: got %0d want 255", stray_count);
        else passed++;
        $display("txn stray_saturate checked");
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_backpressure();
        test_timeout();
        test_tie();
        test_done_hold();
        test_back_to_back();
        test_reset_mid();
        test_stray_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/vscale_htif_pcr_host.md
VSCALE_HTIF_PCR_HOST -- requirements
Module: vscale_htif_pcr_host

Interface
REQ-001 Parameter ADDR_W, default 12 (CSR_ADDR_WIDTH), PCR address width.
REQ-002 Parameter DATA_W, default 64 (HTIF_PCR_WIDTH), PCR data width.
REQ-003 Parameter TIMEOUT, default 1024, max cycles from command acceptance to response before abort; legal range 2..65535.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  host command present.
REQ-007 cmd_ready  output  1  block accepts a command this cycle.
REQ-008 cmd_rw  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_W  target CSR address.
REQ-010 cmd_data  input  DATA_W  write data (ignored on read).
REQ-011 htif_pcr_req_valid  output  1  request to core valid.
REQ-012 htif_pcr_req_ready  input  1  core accepts request.
REQ-013 htif_pcr_req_rw  output  1  registered copy of cmd_rw.
REQ-014 htif_pcr_req_addr  output  ADDR_W  registered copy of cmd_addr.
REQ-015 htif_pcr_req_data  output  DATA_W  registered copy of cmd_data.
REQ-016 htif_pcr_resp_valid  input  1  core response valid.
REQ-017 htif_pcr_resp_ready  output  1  block accepts response.
REQ-018 htif_pcr_resp_data  input  DATA_W  core response data (old CSR value).
REQ-019 done_valid  output  1  completion record available.
REQ-020 done_ready  input  1  host consumes completion.
REQ-021 done_data  output  DATA_W  captured response data.
REQ-022 done_timeout  output  1  completion was a timeout abort.
REQ-023 stray_count  output  8  responses received outside WAIT_RESP, saturating.

Function
REQ-024 FSM states IDLE, SEND, WAIT_RESP, DONE; one transaction outstanding at a time.
REQ-025 cmd_ready = 1 only in IDLE; cmd_valid && cmd_ready registers rw/addr/data, clears timer, moves to SEND.
REQ-026 SEND: htif_pcr_req_valid = 1 from the cycle after acceptance; rw/addr/data stable until handshake.
REQ-027 SEND: req_valid && req_ready -> WAIT_RESP next cycle; req_valid deasserts same edge.
REQ-028 WAIT_RESP: htif_pcr_resp_ready = 1; resp_valid -> capture resp_data into done_data, done_timeout = 0, go DONE.
REQ-029 Timer increments every cycle in SEND and WAIT_RESP; reaching TIMEOUT-1 with no response handshake that cycle -> done_data = 0, done_timeout = 1, go DONE; request abandoned.
REQ-030 Response handshake and timer expiry in same cycle: response wins, done_timeout = 0.
REQ-031 DONE: done_valid = 1, done_data/done_timeout held; done_valid && done_ready -> IDLE next cycle.
REQ-032 htif_pcr_resp_ready = 1 also in IDLE, SEND and DONE to drain late/stray responses; each such handshake discarded, stray_count += 1, saturating at 255.
REQ-033 Write commands complete via response identically to reads (done_data = returned old value).
REQ-034 No new command accepted in the cycle DONE -> IDLE (cmd_ready registered from state).

Reset
REQ-035 reset low asynchronously forces IDLE, timer 0, stray_count 0, done_data 0, done_timeout 0, htif_pcr_req_* 0.
REQ-036 Reset outputs: cmd_ready 0 while reset asserted, 1 first cycle after release; req_valid 0, resp_ready 0 during reset, done_valid 0.
REQ-037 Reset mid-transaction abandons it; no completion produced; subsequent response counted as stray.

Verification
REQ-038 Read: cmd rw=0 addr=0x780; core ready at once, resp 2 cycles later data 0x1234 -> done_valid, done_data=0x1234, done_timeout=0.
REQ-039 Write backpressure: cmd rw=1 addr=0x51E data=0xDEAD, req_ready held low 5 cycles -> req fields stable all 5 cycles, one handshake, then completion.
REQ-040 Timeout: TIMEOUT=16, core never responds -> done_valid after 16 cycles from acceptance, done_timeout=1, done_data=0; later response -> stray_count=1.
REQ-041 Tie: response on the expiry cycle -> done_timeout=0, done_data = response value.
REQ-042 done_ready low 10 cycles -> done_valid and data held, cmd_ready 0 throughout; then IDLE.
REQ-043 Reset asserted in WAIT_RESP -> outputs immediately at reset values; no done_valid after release.
